// File: rtl/counter_arbiter.sv
// counter_arbiter: grants one shared BW-bit up-counter to one of NREQ requesters (round-robin when COUNTER_ARBITER_RR_EN is defined, else fixed priority).
// Latency: done_o pulses L+3 cycles after a request is seen in IDLE; no backpressure, dropping the winner's req_i aborts the run.
module counter_arbiter #(
   parameter int BW   = 3,
   parameter int NREQ = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*BW-1:0]   len_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 busy_o,
   output logic [BW-1:0]        counter_val_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ARB, RUN, DONE} state_t;

   state_t        state;
   logic [BW-1:0] len_q;
   logic [IW-1:0] win_q;
   logic [IW-1:0] win_sel;
   logic          any_req;
   logic          owner_req;

   assign any_req   = |req_i;
   assign owner_req = req_i[win_q];

`ifdef COUNTER_ARBITER_RR_EN
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] rr_next;
   logic [IW:0]   rr_idx;

   // Walk offsets from the top down so the smallest offset from rr_ptr wins.
   always_comb begin
      win_sel = '0;
      rr_idx  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         rr_idx = {1'b0, rr_ptr} + (IW+1)'(i);
         if (rr_idx >= (IW+1)'(NREQ))
            rr_idx = rr_idx - (IW+1)'(NREQ);
         if (req_i[rr_idx[IW-1:0]])
            win_sel = rr_idx[IW-1:0];
      end
   end

   assign rr_next = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         rr_ptr <= '0;
      else if ((state == RUN && !owner_req) || state == DONE)
         rr_ptr <= rr_next;
   end
`else
   always_comb begin
      win_sel = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (req_i[i])
            win_sel = IW'(i);
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= IDLE;
         gnt_o         <= '0;
         done_o        <= '0;
         busy_o        <= 1'b0;
         counter_val_o <= '0;
         len_q         <= '0;
         win_q         <= '0;
      end else begin
         done_o <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state  <= ARB;
                  busy_o <= 1'b1;
               end
            end
            ARB: begin
               counter_val_o <= '0;
               if (any_req) begin
                  state <= RUN;
                  win_q <= win_sel;
                  len_q <= len_i[int'(win_sel)*BW +: BW];
                  gnt_o <= ONE << win_sel;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            RUN: begin
               // Abort takes precedence over completion, even on the last count.
               if (!owner_req) begin
                  state         <= IDLE;
                  gnt_o         <= '0;
                  busy_o        <= 1'b0;
                  counter_val_o <= '0;
               end else if (counter_val_o == len_q) begin
                  state  <= DONE;
                  done_o <= gnt_o;
               end else begin
                  counter_val_o <= counter_val_o + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               gnt_o  <= '0;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues expected per-cycle grant/done/count records, a monitor pops them whenever the DUT shows gnt_o or done_o.
module tb_counter_arbiter;

   localparam int BW   = 3;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*BW-1:0] len;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [BW-1:0]     cnt;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int gnt;
      int done;
      int cnt;
   } exp_t;

   exp_t exp_q[$];

   counter_arbiter #(.BW(BW), .NREQ(NREQ)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .req_i         (req),
      .len_i         (len),
      .gnt_o         (gnt),
      .done_o        (done),
      .busy_o        (busy),
      .counter_val_o (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Request driven in cycle c: ARB at c+1, RUN c+2..c+2+l, DONE at c+l+3.
   task automatic expect_run(input int c, input int w, input int l);
      for (int k = 0; k <= l; k++)
         exp_q.push_back('{c + 2 + k, 1 << w, 0, k});
      exp_q.push_back('{c + l + 3, 1 << w, 1 << w, l});
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (gnt != '0 || done != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: gnt=%b done=%b cnt=%0d, expected idle (cycle %0d)", gnt, done, cnt, cyc);
         end else begin
            e = exp_q.pop_front();
            check("out_cycle", cyc, e.cyc);
            check("gnt", int'(gnt), e.gnt);
            check("done", int'(done), e.done);
            check("counter", int'(cnt), e.cnt);
            check("busy_active", int'(busy), 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c;
      rst_n = 1'b0;
      req   = '0;
      len   = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", int'(gnt), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_counter", int'(cnt), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single request, len 3; len change and a rival request during RUN must be ignored.
      len[1*BW +: BW] = 3'd3;
      req = 4'b0010;
      c = cyc;
      expect_run(c, 1, 3);
      wait_until(c + 2);
      len[1*BW +: BW] = 3'd0;
      wait_until(c + 3);
      req[3] = 1'b1;
      wait_until(c + 6);
      req = '0;
      wait_until(c + 7);
      check("single_idle_gnt", int'(gnt), 0);
      check("single_idle_busy", int'(busy), 0);
      repeat (2) @(negedge clk);

      // Zero length.
      len[0*BW +: BW] = 3'd0;
      req = 4'b0001;
      c = cyc;
      expect_run(c, 0, 0);
      wait_until(c + 3);
      req = '0;
      wait_until(c + 4);
      check("zero_idle_busy", int'(busy), 0);
      repeat (2) @(negedge clk);

      // Maximum length, no wrap.
      len[3*BW +: BW] = 3'd7;
      req = 4'b1000;
      c = cyc;
      expect_run(c, 3, 7);
      wait_until(c + 10);
      req = '0;
      wait_until(c + 11);
      check("max_idle_counter", int'(cnt), 7);
      repeat (2) @(negedge clk);

      // Abort: winner drops request in its second RUN cycle.
      len[2*BW +: BW] = 3'd7;
      req = 4'b0100;
      c = cyc;
      exp_q.push_back('{c + 2, 4, 0, 0});
      exp_q.push_back('{c + 3, 4, 0, 1});
      wait_until(c + 3);
      req = '0;
      wait_until(c + 4);
      check("abort_gnt", int'(gnt), 0);
      check("abort_done", int'(done), 0);
      check("abort_counter", int'(cnt), 0);
      check("abort_busy", int'(busy), 0);
      repeat (10) @(negedge clk);

      // Reset asserted mid-run when the counter reads 2.
      len[1*BW +: BW] = 3'd5;
      req = 4'b0010;
      c = cyc;
      exp_q.push_back('{c + 2, 2, 0, 0});
      exp_q.push_back('{c + 3, 2, 0, 1});
      exp_q.push_back('{c + 4, 2, 0, 2});
      wait_until(c + 4);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_gnt", int'(gnt), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_counter", int'(cnt), 0);
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_gnt", int'(gnt), 0);

      // Contention: all four request, all len 1.
      len = {NREQ{3'd1}};
      req = 4'b1111;
      c = cyc;
      for (int i = 0; i < 5; i++) begin
`ifdef COUNTER_ARBITER_RR_EN
         expect_run(c + 5*i, i % NREQ, 1);
`else
         expect_run(c + 5*i, 0, 1);
`endif
      end
      wait_until(c + 24);
      req = '0;

      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
